vcj_johnson_counter_n: RTL and testbench

//  Parametrised Johnson (twisted-ring) counter; successor to the fixed 4-bit VCJ4RE counters.
//  - Configurable width and reset state; counts up or down; synchronous load by state index.
//  - Binary decode of the current state; illegal-code detection with optional self-recovery.
//  - Used as a glitch-free phase/sequence generator and cascadable prescaler stage (CEO chaining).

---
 rtl/vcj_johnson_counter_n.sv | 147 ++++++++++++++
 tb/tb_vcj_johnson_counter_n.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vcj_johnson_counter_n.sv
// -----------------------------------------------------------------------------
// vcj_johnson_counter_n
//   Parametrised Johnson (twisted-ring) counter with up/down stepping,
//   synchronous load by state index, binary decode of the current state and
//   illegal-code detection with optional self-recovery. It is a glitch-free
//   phase/sequence generator and can be cascaded as a prescaler stage via CEO.
//
// Parameters
//   WIDTH    ring length N (>= 2); the sequence has 2N states
//   INIT_IDX state index entered on clr and on recovery (0 .. 2N-1)
//   RECOVER  1: an illegal code is replaced by code(INIT_IDX) on the next edge
//
// Ports
//   clk     in   1      rising-edge clock
//   clr     in   1      asynchronous active-high reset to code(INIT_IDX)
//   ce      in   1      count enable
//   up      in   1      direction: 1 = up (shift left), 0 = down (shift right)
//   ld      in   1      synchronous load strobe
//   ld_idx  in   IW     state index to load
//   Q       out  WIDTH  Johnson code (registered)
//   idx     out  IW     binary state index of Q (combinational)
//   TC      out  1      terminal count in the current direction
//   HALF    out  1      Q is all ones
//   CEO     out  1      cascade enable: ce & TC & ~err
//   err     out  1      Q is not a legal Johnson code (combinational)
// -----------------------------------------------------------------------------
module vcj_johnson_counter_n #(
    parameter int WIDTH    = 4,
    parameter int INIT_IDX = 0,
    parameter int RECOVER  = 1,
    localparam int unsigned IW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ce,
    input  logic             up,
    input  logic             ld,
    input  logic [IW-1:0]    ld_idx,
    output logic [WIDTH-1:0] Q,
    output logic [IW-1:0]    idx,
    output logic             TC,
    output logic             HALF,
    output logic             CEO,
    output logic             err
);

    // Reject impossible configurations at elaboration time.
    if (WIDTH < 2) begin : g_bad_width
        $error("vcj_johnson_counter_n: WIDTH must be at least 2");
    end
    if (INIT_IDX < 0 || INIT_IDX >= 2 * WIDTH) begin : g_bad_init
        $error("vcj_johnson_counter_n: INIT_IDX must lie in 0 .. 2*WIDTH-1");
    end

    // Johnson code of state index k: k low ones for k <= N, otherwise the
    // top (2N-k) bits set, i.e. bits k-N and above.
    function automatic logic [WIDTH-1:0] code_of(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (k <= WIDTH) begin
                c[i] = (i < k);
            end else begin
                c[i] = (i >= k - WIDTH);
            end
        end
        return c;
    endfunction

    localparam logic [WIDTH-1:0] INIT_CODE = code_of(INIT_IDX);
    // One bit wider than ld_idx so 2N is representable when 2N is a power of 2.
    localparam logic [IW:0]      SEQ_LEN   = (IW + 1)'(2 * WIDTH);
    localparam logic [IW-1:0]    LAST_IDX  = IW'(2 * WIDTH - 1);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [IW-1:0]    idx_c;
    logic             err_c;
    logic             tc_c;
    logic             ld_ok_c;
    int               pc;
    int               trans;

    // Decode: popcount for the index, adjacent-bit transitions for legality.
    // A legal code is 0..01..1 or 1..10..0, i.e. at most one transition.
    always_comb begin
        pc    = 0;
        trans = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (q_q[i]) begin
                pc = pc + 1;
            end
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q_q[i] != q_q[i+1]) begin
                trans = trans + 1;
            end
        end
        err_c = (trans > 1);
        if (q_q[0]) begin
            idx_c = IW'(pc);
        end else if (pc == 0) begin
            idx_c = '0;
        end else begin
            idx_c = IW'(2 * WIDTH - pc);
        end
        tc_c = ~err_c & (up ? (idx_c == LAST_IDX) : (idx_c == '0));
    end

    // Full-width range check; out-of-range loads hold the state.
    assign ld_ok_c = ({1'b0, ld_idx} < SEQ_LEN);

    // Next state: load, then recovery, then count, else hold.
    always_comb begin
        q_d = q_q;
        if (ld) begin
            if (ld_ok_c) begin
                q_d = code_of(32'(ld_idx));
            end
        end else if (err_c && (RECOVER != 0)) begin
            q_d = INIT_CODE;
        end else if (ce) begin
            if (up) begin
                q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
            end else begin
                q_d = {~q_q[0], q_q[WIDTH-1:1]};
            end
        end
    end

    // State register; clr forces the initial code asynchronously.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= INIT_CODE;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q    = q_q;
    assign idx  = idx_c;
    assign err  = err_c;
    assign TC   = tc_c;
    assign HALF = &q_q;
    assign CEO  = ce & tc_c & ~err_c;

endmodule

// File: tb/tb_vcj_johnson_counter_n.sv
// Bench for vcj_johnson_counter_n: three instances (N=4 with recovery,
// N=4 without recovery, N=5 starting at index 3). Stimulus pushes the
// hand-computed expected state into a scoreboard; a negedge monitor pops and
// compares every entry against the instance it names.
module tb_vcj_johnson_counter_n;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       ce  = 1'b0;
    logic       up  = 1'b1;
    logic       ld  = 1'b0;
    logic [2:0] ld_idx = '0;

    logic       clr5 = 1'b0;
    logic       ce5  = 1'b0;
    logic       up5  = 1'b1;
    logic       ld5  = 1'b0;
    logic [3:0] ld_idx5 = '0;

    logic [3:0] q4, qn;
    logic [2:0] idx4, idxn;
    logic       tc4, half4, ceo4, err4;
    logic       tcn, halfn, ceon, errn;
    logic [4:0] q5;
    logic [3:0] idx5;
    logic       tc5, half5, ceo5, err5;

    vcj_johnson_counter_n #(.WIDTH(4), .INIT_IDX(0), .RECOVER(1)) dut (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .ld_idx(ld_idx),
        .Q(q4), .idx(idx4), .TC(tc4), .HALF(half4), .CEO(ceo4), .err(err4)
    );

    vcj_johnson_counter_n #(.WIDTH(4), .INIT_IDX(0), .RECOVER(0)) dut_nr (
        .clk(clk), .clr(clr), .ce(ce), .up(up), .ld(ld), .ld_idx(ld_idx),
        .Q(qn), .idx(idxn), .TC(tcn), .HALF(halfn), .CEO(ceon), .err(errn)
    );

    vcj_johnson_counter_n #(.WIDTH(5), .INIT_IDX(3), .RECOVER(1)) dut5 (
        .clk(clk), .clr(clr5), .ce(ce5), .up(up5), .ld(ld5), .ld_idx(ld_idx5),
        .Q(q5), .idx(idx5), .TC(tc5), .HALF(half5), .CEO(ceo5), .err(err5)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    sel;      // 0: dut, 1: dut_nr, 2: dut5
        int    q;
        int    idx;
        bit    idx_valid;
        bit    err;
        bit    up;
        bit    ce;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Queue the state expected at the coming negedge for one instance.
    task automatic expect_state(input string name, input int sel, input int q,
                                input int idx, input bit e);
        exp_t x;
        x.name      = name;
        x.sel       = sel;
        x.q         = q;
        x.idx       = idx;
        x.idx_valid = !e;
        x.err       = e;
        x.up        = (sel == 2) ? up5 : up;
        x.ce        = (sel == 2) ? ce5 : ce;
        sb.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every pending expectation against the live outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   aq, aidx, n, lastidx;
        bit   atc, ahalf, aceo, aerr, etc, ehalf, eceo, bad;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: begin aq = int'(q4); aidx = int'(idx4); atc = tc4; ahalf = half4; aceo = ceo4; aerr = err4; end
                1: begin aq = int'(qn); aidx = int'(idxn); atc = tcn; ahalf = halfn; aceo = ceon; aerr = errn; end
                default: begin aq = int'(q5); aidx = int'(idx5); atc = tc5; ahalf = half5; aceo = ceo5; aerr = err5; end
            endcase
            n       = (e.sel == 2) ? 5 : 4;
            lastidx = 2 * n - 1;
            etc     = !e.err && (e.up ? (e.idx == lastidx) : (e.idx == 0));
            ehalf   = (e.q == (1 << n) - 1);
            eceo    = e.ce && etc;
            bad     = (aq != e.q) || (aerr != e.err) || (atc != etc) ||
                      (ahalf != ehalf) || (aceo != eceo) ||
                      (e.idx_valid && (aidx != e.idx));
            n_checks++;
            if (bad) begin
                n_fail++;
                $display("FAIL %s: got Q=%0h idx=%0d TC=%0b HALF=%0b CEO=%0b err=%0b, expected Q=%0h idx=%0d TC=%0b HALF=%0b CEO=%0b err=%0b",
                         e.name, aq, aidx, atc, ahalf, aceo, aerr,
                         e.q, e.idx, etc, ehalf, eceo, e.err);
            end
        end
    end

    int up_q[8]   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    int up_idx[8] = '{1, 2, 3, 4, 5, 6, 7, 0};
    int dn_q[5]   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111};
    int dn_idx[5] = '{7, 6, 5, 4, 3};
    int n5_q[10]  = '{5'b01111, 5'b11111, 5'b11110, 5'b11100, 5'b11000,
                      5'b10000, 5'b00000, 5'b00001, 5'b00011, 5'b00111};
    int n5_idx[10] = '{4, 5, 6, 7, 8, 9, 0, 1, 2, 3};

    initial begin
        #1;
        clr  = 1'b1;
        clr5 = 1'b1;

        // T1 reset
        cyc();
        expect_state("rst_up", 0, 4'b0000, 0, 1'b0);
        cyc();
        up = 1'b0;
        expect_state("rst_dn", 0, 4'b0000, 0, 1'b0);
        cyc();
        clr = 1'b0; ce = 1'b1; up = 1'b1;
        expect_state("rst_rel", 0, 4'b0000, 0, 1'b0);

        // T2 up count through the full cycle
        for (int i = 0; i < 8; i++) begin
            cyc();
            expect_state("up_cnt", 0, up_q[i], up_idx[i], 1'b0);
        end
        cyc();
        ce = 1'b0;
        expect_state("up_stop", 0, 4'b0001, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_state("hold", 0, 4'b0001, 1, 1'b0);
        end
        ce = 1'b1;
        cyc();
        clr = 1'b1;
        expect_state("clr_mid", 0, 4'b0000, 0, 1'b0);

        // T3 down count with reversal at index 3
        cyc();
        clr = 1'b0; up = 1'b0;
        expect_state("dn_start", 0, 4'b0000, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 4) up = 1'b1;
            expect_state("dn_cnt", 0, dn_q[i], dn_idx[i], 1'b0);
        end
        cyc();
        ce = 1'b0;
        expect_state("reverse", 0, 4'b1111, 4, 1'b0);

        // T4 load, load beats count
        cyc();
        ld = 1'b1; ld_idx = 3'd5;
        expect_state("ld_pre", 0, 4'b1111, 4, 1'b0);
        cyc();
        ld_idx = 3'd2; ce = 1'b1; up = 1'b1;
        expect_state("ld5", 0, 4'b1110, 5, 1'b0);
        cyc();
        ld = 1'b0; ce = 1'b0;
        expect_state("ld_wins", 0, 4'b0011, 2, 1'b0);

        // T5 recovery with ce=1, then with ce=0
        cyc();
        force dut.q_q = 4'b0101;
        ce = 1'b1;
        expect_state("err_ce1", 0, 4'b0101, 0, 1'b1);
        @(negedge clk); #1;
        release dut.q_q;
        cyc();
        ce = 1'b0;
        expect_state("rec_ce1", 0, 4'b0000, 0, 1'b0);
        cyc();
        force dut.q_q = 4'b0101;
        expect_state("err_ce0", 0, 4'b0101, 0, 1'b1);
        @(negedge clk); #1;
        release dut.q_q;
        cyc();
        expect_state("rec_ce0", 0, 4'b0000, 0, 1'b0);

        // T5 no recovery: illegal code persists and keeps shifting
        cyc();
        force dut_nr.q_q = 4'b0101;
        expect_state("nr_err", 1, 4'b0101, 0, 1'b1);
        @(negedge clk); #1;
        release dut_nr.q_q;
        cyc();
        ce = 1'b1; up = 1'b1;
        expect_state("nr_hold", 1, 4'b0101, 0, 1'b1);
        cyc();
        expect_state("nr_shift1", 1, 4'b1011, 0, 1'b1);
        cyc();
        ce = 1'b0;
        expect_state("nr_shift2", 1, 4'b0110, 0, 1'b1);

        // T6 N=5, INIT_IDX=3
        cyc();
        expect_state("n5_rst", 2, 5'b00111, 3, 1'b0);
        cyc();
        clr5 = 1'b0; ce5 = 1'b1; up5 = 1'b1;
        expect_state("n5_rel", 2, 5'b00111, 3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (i == 9) ce5 = 1'b0;
            expect_state("n5_cnt", 2, n5_q[i], n5_idx[i], 1'b0);
        end
        cyc();
        ld5 = 1'b1; ld_idx5 = 4'd12; ce5 = 1'b1;
        expect_state("n5_ldpre", 2, 5'b00111, 3, 1'b0);
        cyc();
        ld_idx5 = 4'd9;
        expect_state("n5_ld_oob", 2, 5'b00111, 3, 1'b0);
        cyc();
        ld5 = 1'b0; ce5 = 1'b0;
        expect_state("n5_ld9", 2, 5'b10000, 9, 1'b0);
        cyc();
        ce5 = 1'b1;
        expect_state("n5_ceo", 2, 5'b10000, 9, 1'b0);
        cyc();
        ce5 = 1'b0;
        expect_state("n5_wrap", 2, 5'b00000, 0, 1'b0);

        @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
